sop_sweep_ctrl: RTL and testbench
=================================

SOP_SWEEP_CTRL -- requirements
Module: sop_sweep_ctrl

Interface
REQ-001 Parameter: EXPECTED, 16'h1894, golden truth table; bit m is the required output for minterm m (minterms 2,4,7,11,12).
REQ-002 Parameter: SETTLE, 1, number of cycles (1..7) a vector is held before the function output is sampled.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin a 16-minterm sweep; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminates a sweep in progress; returns to IDLE without done.
REQ-007 Port: s  input  1  output of the combinational 4-input function under control.
REQ-008 Port: x, y, w, z  output  1 each  function inputs; x is the MSB of the minterm index, z the LSB.
REQ-009 Port: m  output  4  index of the minterm currently applied.
REQ-010 Port: busy  output  1  high in every state except IDLE and DONE.
REQ-011 Port: done  output  1  one-cycle pulse when a sweep completes.
REQ-012 Port: table_out  output  16  captured truth table; bit m holds s sampled for minterm m.
REQ-013 Port: pass  output  1  high when table_out equals EXPECTED; valid while done is high and held until the next start.
REQ-014 Port: err_count  output  5  number of minterms whose sampled s differs from EXPECTED (0..16).

Function
REQ-015 FSM states: IDLE, APPLY, SAMPLE, DONE.
REQ-016 IDLE: start=1 and abort=0 -> APPLY; m, table_out and err_count clear to 0; pass clears to 0.
REQ-017 APPLY: {x,y,w,z}=m, held for exactly SETTLE cycles via an internal settle counter, then -> SAMPLE.
REQ-018 SAMPLE (1 cycle): table_out[m] <= s; err_count increments if s != EXPECTED[m]; if m=15 -> DONE, else m <= m+1 and -> APPLY.
REQ-019 m never wraps within a sweep; the 15->0 transition occurs only on the next start.
REQ-020 DONE (1 cycle): done=1; pass = (table_out == EXPECTED); -> IDLE.
REQ-021 Sweep latency: start accepted at edge 0 -> done high for exactly one cycle, 16*(SETTLE+1)+1 cycles later (33 cycles at SETTLE=1).
REQ-022 start while busy or in DONE is ignored; it is not queued.
REQ-023 abort in APPLY or SAMPLE -> IDLE next cycle; table_out and err_count retain their partial values; done stays 0; pass stays 0.
REQ-024 start and abort high together in IDLE: abort wins and the FSM stays in IDLE.
REQ-025 {x,y,w,z} hold the last applied vector in IDLE and DONE; they never show X after reset.

Reset
REQ-026 reset=1 at a clock edge -> state IDLE; m=0; {x,y,w,z}=0; busy=0; done=0; table_out=0; err_count=0; pass=0; settle counter=0.
REQ-027 reset takes priority over start, abort and every FSM transition, including mid-sweep.

Configuration
REQ-028 Macro SOP_SWEEP_STOP_ON_FAIL_EN: when defined, the first mismatch in SAMPLE forces -> DONE after capture; m holds the failing index; pass=0; err_count=1.
REQ-029 When SOP_SWEEP_STOP_ON_FAIL_EN is undefined, all 16 minterms are always swept regardless of mismatches.

Verification
REQ-030 Correct function, SETTLE=1, start pulse -> done 33 cycles later; table_out=16'h1894; pass=1; err_count=0.
REQ-031 s tied to 0, macro undefined -> table_out=16'h0000; err_count=5; pass=0; m=15 at done.
REQ-032 s tied to 0, macro defined -> done after minterm 2 is sampled; m=2; err_count=1; pass=0.
REQ-033 abort asserted while m=7 -> IDLE next cycle; done never pulses; table_out bits 0..6 retain their captured values.
REQ-034 reset asserted mid-sweep at m=9 -> all outputs zero next cycle; a following start runs a full sweep from m=0.
REQ-035 start held high for 40 cycles -> exactly one sweep runs; start in DONE is ignored; a second sweep begins only from IDLE.

Source files
------------

// File: rtl/sop_sweep_ctrl_if.sv
// Handshake and result bundle between a truth-table sweep controller and its driver.
// The slave modport is the controller side; the master modport is the requester/plant side.
interface sop_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic        s;
    logic        x;
    logic        y;
    logic        w;
    logic        z;
    logic [3:0]  m;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic        pass;
    logic [4:0]  err_count;

    modport slave (
        input  start, abort, s,
        output x, y, w, z, m, busy, done, table_out, pass, err_count
    );

    modport master (
        output start, abort, s,
        input  x, y, w, z, m, busy, done, table_out, pass, err_count
    );
endinterface

// File: rtl/sop_sweep_ctrl.sv
// Sweeps all 16 minterms of a 4-input function, captures its truth table and compares it to EXPECTED.
// Optional build macro SOP_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching minterm.
module sop_sweep_ctrl #(
    parameter logic [15:0] EXPECTED = 16'h1894,
    parameter int unsigned SETTLE   = 1
) (
    input  logic               clk,
    input  logic               reset,
    sop_sweep_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 32'd1);

    state_t      state_q, state_d;
    logic [3:0]  m_q, m_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  err_q, err_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        mismatch_s;

    // Next-state and datapath updates for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        table_d    = table_q;
        err_d      = err_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        mismatch_s = (bus.s != EXPECTED[m_q]);

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = APPLY;
                    m_d     = 4'd0;
                    cnt_d   = 3'd0;
                    table_d = 16'h0000;
                    err_d   = 5'd0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            SAMPLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    table_d[m_q] = bus.s;
                    if (mismatch_s) begin
                        err_d = err_q + 5'd1;
                    end else begin
                        err_d = err_q;
                    end
`ifdef SOP_SWEEP_STOP_ON_FAIL_EN
                    if (mismatch_s || (m_q == 4'd15)) begin
                        state_d = DONE;
                    end else begin
                        m_d     = m_q + 4'd1;
                        state_d = APPLY;
                    end
`else
                    if (m_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        m_d     = m_q + 4'd1;
                        state_d = APPLY;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                pass_d  = (table_q == EXPECTED);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == APPLY) || (state_d == SAMPLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= 4'd0;
            cnt_q   <= 3'd0;
            table_q <= 16'h0000;
            err_q   <= 5'd0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // The applied vector is the minterm register itself, so it holds in IDLE/DONE.
    assign bus.x         = m_q[3];
    assign bus.y         = m_q[2];
    assign bus.w         = m_q[1];
    assign bus.z         = m_q[0];
    assign bus.m         = m_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Directed bench for sop_sweep_ctrl: a plant model drives s, scenarios check latency and captured results.
module tb_sop_sweep_ctrl;

    localparam int SETTLE  = 1;
    localparam int LATENCY = 16 * (SETTLE + 1) + 1;

    logic        clk;
    logic        reset;
    logic        plant_ok;
    logic [15:0] golden;
    int          n_total;
    int          n_bad;

    sop_sweep_ctrl_if bus ();

    sop_sweep_ctrl #(.EXPECTED(16'h1894), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.s = plant_ok ? golden[{bus.x, bus.y, bus.w, bus.z}] : 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic wait_m(input logic [3:0] target);
        int n;
        n = 0;
        while (bus.m != target && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check_eq("m_reached", {28'd0, bus.m}, {28'd0, target});
    endtask

    initial begin
        int lat;
        int n_done;
        logic b33;
        logic b34;
        n_total   = 0;
        n_bad     = 0;
        golden    = 16'h1894;
        plant_ok  = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        check_eq("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done",  {31'd0, bus.done}, 32'd0);
        check_eq("rst_table", {16'd0, bus.table_out}, 32'd0);
        check_eq("rst_err",   {27'd0, bus.err_count}, 32'd0);
        check_eq("rst_vec",   {28'd0, bus.x, bus.y, bus.w, bus.z}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Correct function: full sweep, pass.
        pulse_start();
        check_eq("run_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("run_m0",   {28'd0, bus.m}, 32'd0);
        wait_done(lat);
        check_eq("ok_latency", lat, LATENCY);
        check_eq("ok_table",   {16'd0, bus.table_out}, 32'h1894);
        check_eq("ok_pass",    {31'd0, bus.pass}, 32'd1);
        check_eq("ok_err",     {27'd0, bus.err_count}, 32'd0);
        check_eq("ok_m15",     {28'd0, bus.m}, 32'd15);
        @(posedge clk);
        @(negedge clk);
        check_eq("done_1cyc", {31'd0, bus.done}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("pass_held", {31'd0, bus.pass}, 32'd1);
        check_eq("idle_vec",  {28'd0, bus.x, bus.y, bus.w, bus.z}, 32'd15);

        // Stuck-at-0 function.
        plant_ok = 1'b0;
        pulse_start();
        check_eq("pass_clr", {31'd0, bus.pass}, 32'd0);
        wait_done(lat);
`ifdef SOP_SWEEP_STOP_ON_FAIL_EN
        check_eq("s0_latency", lat, 7);
        check_eq("s0_m",       {28'd0, bus.m}, 32'd2);
        check_eq("s0_err",     {27'd0, bus.err_count}, 32'd1);
`else
        check_eq("s0_latency", lat, LATENCY);
        check_eq("s0_m",       {28'd0, bus.m}, 32'd15);
        check_eq("s0_err",     {27'd0, bus.err_count}, 32'd5);
`endif
        check_eq("s0_table", {16'd0, bus.table_out}, 32'd0);
        check_eq("s0_pass",  {31'd0, bus.pass}, 32'd0);
        plant_ok = 1'b1;
        @(negedge clk);

        // Abort at m=7.
        pulse_start();
        wait_m(4'd7);
        check_eq("vec_m7", {28'd0, bus.x, bus.y, bus.w, bus.z}, 32'd7);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("ab_busy",  {31'd0, bus.busy}, 32'd0);
        check_eq("ab_m",     {28'd0, bus.m}, 32'd7);
        check_eq("ab_table", {16'd0, bus.table_out}, 32'h0014);
        check_eq("ab_err",   {27'd0, bus.err_count}, 32'd0);
        check_eq("ab_pass",  {31'd0, bus.pass}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) n_done++;
        end
        check_eq("ab_no_done", n_done, 0);

        // Reset mid-sweep at m=9, then a clean sweep.
        pulse_start();
        wait_m(4'd9);
        check_eq("m9_table", {16'd0, bus.table_out}, 32'h0094);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("mr_m",     {28'd0, bus.m}, 32'd0);
        check_eq("mr_busy",  {31'd0, bus.busy}, 32'd0);
        check_eq("mr_table", {16'd0, bus.table_out}, 32'd0);
        check_eq("mr_vec",   {28'd0, bus.x, bus.y, bus.w, bus.z}, 32'd0);
        pulse_start();
        check_eq("mr_m0", {28'd0, bus.m}, 32'd0);
        wait_done(lat);
        check_eq("mr_latency", lat, LATENCY);
        check_eq("mr_pass",    {31'd0, bus.pass}, 32'd1);
        repeat (2) @(negedge clk);

        // Start held high for 40 cycles.
        bus.start = 1'b1;
        n_done = 0;
        b33 = 1'b1;
        b34 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) n_done++;
            if (i == 33) b33 = bus.busy;
            if (i == 34) b34 = bus.busy;
        end
        bus.start = 1'b0;
        check_eq("hold_one_done",  n_done, 1);
        check_eq("hold_done_idle", {31'd0, b33}, 32'd0);
        check_eq("hold_restart",   {31'd0, b34}, 32'd1);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("hold_abort", {31'd0, bus.busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
